// File: rtl/reg_bank_write_arbiter_pkg.sv
// Shared types and sizing helpers for the register-bank write arbiter.
// Imported by the interface, the round-robin arbiter and the top level.
package reg_bank_arb_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int WIDTH_DFLT = 8;
    localparam int NREQ_DFLT  = 4;
    localparam int NREG_DFLT  = 8;
    localparam int AW_DFLT    = idx_w(NREG_DFLT);
    localparam int IW_DFLT    = idx_w(NREQ_DFLT);

endpackage

// File: rtl/reg_bank_write_arbiter_if.sv
// Request/grant bus plus read port of the shared register bank.
// The master side drives requests; the bank arbiter is the slave.
interface reg_bank_write_arbiter_if
    import reg_bank_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DFLT,
    parameter int NREQ  = NREQ_DFLT,
    parameter int NREG  = NREG_DFLT
);
    localparam int AW = idx_w(NREG);
    localparam int IW = idx_w(NREQ);

    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_lock;
    logic [NREQ-1:0][AW-1:0]   req_addr;
    logic [NREQ-1:0][WIDTH-1:0] req_data;
    logic [NREQ-1:0]           req_ready;
    logic [IW-1:0]             grant_id;
    logic                      locked;
    logic [AW-1:0]             rd_addr;
    logic [WIDTH-1:0]          rd_data;

    modport master (
        output req_valid, req_lock, req_addr, req_data, rd_addr,
        input  req_ready, grant_id, locked, rd_data
    );

    modport slave (
        input  req_valid, req_lock, req_addr, req_data, rd_addr,
        output req_ready, grant_id, locked, rd_data
    );

endinterface

// File: rtl/reg_bank_write_arbiter_rr_arbiter.sv
// Round-robin picker: first request at/after the pointer, with wrap.
// Pointer moves to winner+1 on advance unless hold is set.
module rr_arbiter
    import reg_bank_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DFLT,
    localparam int IW  = idx_w(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    input  logic            hold,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_id
);
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Scan upward from the pointer and grant the first requester.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx] && gnt == '0) begin
                gnt[idx] = 1'b1;
                gnt_id   = IW'(idx);
            end
        end
    end

    // Next pointer: one past the winner, wrapping at NREQ-1.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && !hold) begin
            if (int'(gnt_id) == NREQ - 1) ptr_d = '0;
            else ptr_d = gnt_id + IW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Shared register bank with one round-robin arbitrated write port,
// burst locking by a single owner and a combinational read port.
module reg_bank_write_arbiter
    import reg_bank_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DFLT,
    parameter int NREQ  = NREQ_DFLT,
    parameter int NREG  = NREG_DFLT
) (
    input  logic                   clk,
    input  logic                   reset,
    reg_bank_write_arbiter_if.slave bus
);
    localparam int AW = idx_w(NREG);
    localparam int IW = idx_w(NREQ);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [NREQ-1:0]  arb_req;
    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_id;
    logic             xfer;
    logic             win_lock;
    logic             hold;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] bank [NREG];

    // While locked only the owner may compete for the port.
    always_comb begin
        arb_req = bus.req_valid;
        if (state_q == LOCKED)
            arb_req = bus.req_valid & (NREQ'(1) << owner_q);
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .rst_n   (reset),
        .req     (arb_req),
        .advance (xfer),
        .hold    (hold),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    assign xfer     = reset && (gnt != '0);
    assign win_lock = bus.req_lock[gnt_id];
    assign hold     = (state_q == LOCKED) && win_lock;
    assign wr_addr  = bus.req_addr[gnt_id];
    assign wr_data  = bus.req_data[gnt_id];

    assign bus.req_ready = reset ? gnt : '0;
    assign bus.grant_id  = reset ? gnt_id : '0;
    assign bus.locked    = (state_q == LOCKED);

    // Lock FSM: enter on a locking write, leave on owner's unlocking write.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (xfer && win_lock) begin
                    state_d = LOCKED;
                    owner_d = gnt_id;
                end
            end
            LOCKED: begin
                if (xfer && !win_lock) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and lock owner registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // One register per bank entry; out-of-range addresses match none.
    for (genvar r = 0; r < NREG; r++) begin : g_reg
        logic [WIDTH-1:0] reg_q;
        logic [WIDTH-1:0] reg_d;

        // Load on a transfer that targets this entry.
        always_comb begin
            reg_d = reg_q;
            if (xfer && int'(wr_addr) == r) reg_d = wr_data;
        end

        // Bank entry register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) reg_q <= '0;
            else reg_q <= reg_d;
        end

        assign bank[r] = reg_q;
    end

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        bus.rd_data = '0;
        if (int'(bus.rd_addr) < NREG) bus.rd_data = bank[bus.rd_addr];
    end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Bench for reg_bank_write_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_reg_bank_write_arbiter;
    import reg_bank_arb_pkg::*;

    localparam int W  = 8;
    localparam int NQ = 4;
    localparam int NR = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    reg_bank_write_arbiter_if #(.WIDTH(W), .NREQ(NQ), .NREG(NR)) bus ();
    reg_bank_write_arbiter_if #(.WIDTH(W), .NREQ(NQ), .NREG(6))  bus6 ();

    reg_bank_write_arbiter #(.WIDTH(W), .NREQ(NQ), .NREG(NR)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    reg_bank_write_arbiter #(.WIDTH(W), .NREQ(NQ), .NREG(6)) u_dut6 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus6.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int       m_ptr;
    int       m_owner;
    bit       m_locked;
    logic [W-1:0] m_bank [NR];

    logic [NQ-1:0] e_ready;
    int            e_gid;
    logic          e_locked;
    logic [W-1:0]  e_rd;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ptr    = 0;
        m_owner  = 0;
        m_locked = 0;
        for (int i = 0; i < NR; i++) m_bank[i] = '0;
    endfunction

    function automatic void model_eval();
        e_ready  = '0;
        e_gid    = 0;
        e_locked = rst_n && m_locked;
        e_rd     = m_bank[bus.rd_addr];
        if (rst_n) begin
            if (m_locked) begin
                if (bus.req_valid[m_owner]) begin
                    e_ready[m_owner] = 1'b1;
                    e_gid = m_owner;
                end
            end else begin
                for (int k = NQ - 1; k >= 0; k--) begin
                    int c;
                    c = (m_ptr + k) % NQ;
                    if (bus.req_valid[c]) begin
                        e_ready = '0;
                        e_ready[c] = 1'b1;
                        e_gid = c;
                    end
                end
            end
        end
    endfunction

    function automatic void model_commit();
        int w;
        if (!rst_n || e_ready == '0) return;
        w = e_gid;
        m_bank[bus.req_addr[w]] = bus.req_data[w];
        if (!m_locked) begin
            m_ptr = (w + 1) % NQ;
            if (bus.req_lock[w]) begin
                m_locked = 1;
                m_owner  = w;
            end
        end else if (!bus.req_lock[w]) begin
            m_locked = 0;
            m_ptr    = (m_owner + 1) % NQ;
        end
    endfunction

    // Compare DUT outputs against the model after inputs settle.
    task automatic settle();
        #1;
        if (!rst_n) model_reset();
        model_eval();
        chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
        chk("locked", 32'(bus.locked), 32'(e_locked));
        chk("rd_data", 32'(bus.rd_data), 32'(e_rd));
        if (e_ready != '0) chk("grant_id", 32'(bus.grant_id), 32'(e_gid));
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.rd_addr   = '0;
    endtask

    initial begin
        logic [1:0] rr_exp [5];
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        idle_inputs();
        bus6.req_valid = '0;
        bus6.req_lock  = '0;
        bus6.req_addr  = '0;
        bus6.req_data  = '0;
        bus6.rd_addr   = '0;
        model_reset();

        @(negedge clk);
        settle();
        chk("rst_ready_lit", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        advance();

        // NREG=6 instance: out-of-range write is acknowledged but dropped
        bus6.req_valid = 4'b0100;
        bus6.req_addr[2] = 3'd5;
        bus6.req_data[2] = 8'h33;
        #1;
        chk("n6_seed_rdy", 32'(bus6.req_ready), 32'h4);
        @(posedge clk);
        @(negedge clk);
        bus6.req_valid = 4'b0001;
        bus6.req_addr[0] = 3'd7;
        bus6.req_data[0] = 8'hFF;
        #1;
        chk("n6_oob_rdy", 32'(bus6.req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        bus6.req_valid = '0;
        for (int r = 0; r < 6; r++) begin
            bus6.rd_addr = 3'(r);
            #1;
            chk("n6_bank", 32'(bus6.rd_data), (r == 5) ? 32'h33 : 32'h0);
        end
        bus6.req_valid = 4'b1111;
        #1;
        chk("n6_ptr", 32'(bus6.grant_id), 32'd1);
        bus6.req_valid = '0;
        @(negedge clk);

        // Round-robin with every requester valid
        for (int i = 0; i < NQ; i++) begin
            bus.req_addr[i] = 3'(i);
            bus.req_data[i] = 8'hA0 + 8'(i);
        end
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("rr_gid_lit", 32'(bus.grant_id), 32'(rr_exp[k]));
            advance();
        end
        bus.req_valid = '0;
        for (int i = 0; i < NQ; i++) begin
            bus.rd_addr = 3'(i);
            settle();
            chk("rr_bank_lit", 32'(bus.rd_data), 32'hA0 + i);
        end

        // Lock burst by req1 while req0/req2 contend
        bus.req_valid = 4'b0111;
        bus.req_lock[1] = 1'b1;
        bus.req_addr[1] = 3'd3;
        bus.req_data[1] = 8'h77;
        settle();
        chk("lk_win_lit", 32'(bus.grant_id), 32'd1);
        advance();
        settle();
        chk("lk_locked_lit", 32'(bus.locked), 32'd1);
        chk("lk_ready_lit", 32'(bus.req_ready), 32'h2);
        bus.req_lock[1] = 1'b0;
        bus.req_data[1] = 8'h78;
        settle();
        advance();
        settle();
        chk("lk_unlock_lit", 32'(bus.locked), 32'd0);
        chk("lk_next_lit", 32'(bus.grant_id), 32'd2);
        advance();
        bus.req_valid = '0;

        // Lock stall: owner req3 goes quiet for 5 cycles
        bus.req_valid = 4'b1000;
        bus.req_lock[3] = 1'b1;
        settle();
        advance();
        bus.req_valid = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("st_ready_lit", 32'(bus.req_ready), 32'h0);
            chk("st_locked_lit", 32'(bus.locked), 32'd1);
            advance();
        end
        bus.req_valid = 4'b1111;
        bus.req_lock[3] = 1'b0;
        settle();
        chk("st_resume_lit", 32'(bus.req_ready), 32'h8);
        advance();
        settle();
        chk("st_free_lit", 32'(bus.locked), 32'd0);
        bus.req_valid = '0;
        bus.req_lock  = '0;

        // Read/write collision on reg 2 (holds A2 here)
        bus.req_valid = 4'b0001;
        bus.req_addr[0] = 3'd2;
        bus.req_data[0] = 8'h5A;
        bus.rd_addr = 3'd2;
        settle();
        chk("col_old_lit", 32'(bus.rd_data), 32'hA2);
        advance();
        bus.req_valid = '0;
        settle();
        chk("col_new_lit", 32'(bus.rd_data), 32'h5A);

        // Reset mid-burst
        bus.req_valid = 4'b1111;
        bus.req_lock  = 4'b1111;
        settle();
        advance();
        rst_n = 1'b0;
        for (int r = 0; r < NR; r++) begin
            bus.rd_addr = 3'(r);
            settle();
            chk("rst_rd_lit", 32'(bus.rd_data), 32'h0);
            chk("rst_locked_lit", 32'(bus.locked), 32'h0);
        end
        advance();
        settle();
        chk("rst_hold_lit", 32'(bus.req_ready), 32'h0);
        rst_n = 1'b1;
        settle();
        advance();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bus.req_valid = 4'($urandom);
            bus.req_lock  = 4'($urandom & $urandom);
            for (int i = 0; i < NQ; i++) begin
                bus.req_addr[i] = 3'($urandom);
                bus.req_data[i] = 8'($urandom);
            end
            bus.rd_addr = 3'($urandom);
            if ($urandom_range(0, 79) == 0) rst_n = 1'b0;
            settle();
            advance();
            rst_n = 1'b1;
        end

        idle_inputs();
        settle();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
